rob_retire_unit: RTL

In-order retirement engine at the head (read end) of the reorder buffer. Each cycle it inspects up to NUM_READ entries starting at the ROB read pointer and pops the longest contiguous prefix of completed entries. It commits their results to the architectural register file and issues the pop mask to the ROB FIFO controller. On a retired mispredicted branch it squashes the pipeline through a flush/ack handshake.

---
 rtl/rob_pkg.sv | 26 ++
 rtl/retire_select.sv | 67 ++++++
 rtl/rob_retire_unit.sv | 127 ++++++++++++
 3 files changed

// File: rtl/rob_pkg.sv
// rob_pkg
// Shared types for the reorder-buffer retirement path.
//   retire_state_e : retirement FSM states (RUN, FLUSH, WAIT_ACK)
//   rob_entry_t    : one ROB entry as held by the ROB storage array
package rob_pkg;

  localparam int ROB_AREG_W = 5;
  localparam int ROB_DATA_W = 32;
  localparam int ROB_PC_W   = 32;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    WAIT_ACK = 2'd2
  } retire_state_e;

  typedef struct packed {
    logic                  done;
    logic                  mispred;
    logic                  wen;
    logic [ROB_AREG_W-1:0] rd;
    logic [ROB_DATA_W-1:0] data;
    logic [ROB_PC_W-1:0]   target;
  } rob_entry_t;

endpackage

// File: rtl/retire_select.sv
// retire_select
// Combinational lane selection for in-order retirement.
//   enable         : retirement allowed this cycle (FSM in RUN)
//   occupied       : number of valid ROB entries
//   ent_done/ent_mispred/ent_wen/ent_rd/ent_target : per-lane entry fields
//   pop            : thermometer mask of lanes retiring this cycle
//   commit_en      : per-lane architectural write enable after suppression
//   mispred_hit    : a retiring lane is a mispredicted branch
//   mispred_target : correct target of the oldest such lane
module retire_select #(
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_READ   = 2,
  parameter int AREG_W     = 5,
  parameter int PC_W       = 32
) (
  input  logic                             enable,
  input  logic [ADDR_WIDTH:0]              occupied,
  input  logic [NUM_READ-1:0]              ent_done,
  input  logic [NUM_READ-1:0]              ent_mispred,
  input  logic [NUM_READ-1:0]              ent_wen,
  input  logic [NUM_READ-1:0][AREG_W-1:0]  ent_rd,
  input  logic [NUM_READ-1:0][PC_W-1:0]    ent_target,
  output logic [NUM_READ-1:0]              pop,
  output logic [NUM_READ-1:0]              commit_en,
  output logic                             mispred_hit,
  output logic [PC_W-1:0]                  mispred_target
);

  logic chain;

  // Walk lanes oldest-first; the chain breaks at the first lane that is
  // beyond the occupancy, not done, or right after a mispredicted branch.
  // Lanes past NUM_READ never exist, so occupancy is implicitly clamped.
  always_comb begin
    pop            = '0;
    mispred_hit    = 1'b0;
    mispred_target = '0;
    chain          = enable;
    for (int i = 0; i < NUM_READ; i++) begin
      if (chain && ((ADDR_WIDTH+1)'(i) < occupied) && ent_done[i]) begin
        pop[i] = 1'b1;
        if (ent_mispred[i]) begin
          mispred_hit    = 1'b1;
          mispred_target = ent_target[i];
          chain          = 1'b0;
        end
      end else begin
        chain = 1'b0;
      end
    end
  end

  // A write is dropped when a younger lane retiring in the same cycle
  // overwrites the same register; only the youngest value matters.
  always_comb begin
    commit_en = '0;
    for (int i = 0; i < NUM_READ; i++) begin
      commit_en[i] = pop[i] & ent_wen[i] & (ent_rd[i] != '0);
      for (int j = i + 1; j < NUM_READ; j++) begin
        if (pop[j] && ent_wen[j] && (ent_rd[j] == ent_rd[i])) begin
          commit_en[i] = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/rob_retire_unit.sv
// rob_retire_unit
// In-order retirement at the ROB head: pops the longest completed prefix,
// commits results to the architectural register file and squashes the
// pipeline on a retired mispredicted branch.
//   clk, reset              : clock, synchronous active-high reset
//   occupied, head_ptr      : ROB occupancy and read pointer
//   r_addr                  : ROB read addresses per lane
//   ent_*                   : entry fields read at r_addr
//   rd                      : pop mask to the FIFO controller
//   commit_valid/rd/data    : registered register-file write port
//   flush, redirect_pc      : squash pulse and fetch redirect
//   flush_ack               : squash complete
//   instret                 : retired-instruction counter
module rob_retire_unit
  import rob_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_READ   = 2,
  parameter int AREG_W     = 5,
  parameter int DATA_W     = 32,
  parameter int PC_W       = 32
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [ADDR_WIDTH:0]                occupied,
  input  logic [ADDR_WIDTH-1:0]              head_ptr,
  output logic [NUM_READ-1:0][ADDR_WIDTH-1:0] r_addr,
  input  logic [NUM_READ-1:0]                ent_done,
  input  logic [NUM_READ-1:0]                ent_mispred,
  input  logic [NUM_READ-1:0]                ent_wen,
  input  logic [NUM_READ-1:0][AREG_W-1:0]    ent_rd,
  input  logic [NUM_READ-1:0][DATA_W-1:0]    ent_data,
  input  logic [NUM_READ-1:0][PC_W-1:0]      ent_target,
  output logic [NUM_READ-1:0]                rd,
  output logic [NUM_READ-1:0]                commit_valid,
  output logic [NUM_READ-1:0][AREG_W-1:0]    commit_rd,
  output logic [NUM_READ-1:0][DATA_W-1:0]    commit_data,
  output logic                               flush,
  output logic [PC_W-1:0]                    redirect_pc,
  input  logic                               flush_ack,
  output logic [31:0]                        instret
);

  retire_state_e           state;
  logic [NUM_READ-1:0]     commit_en;
  logic                    mispred_hit;
  logic [PC_W-1:0]         mispred_target;
  logic [31:0]             pop_count;

  // Read addresses wrap naturally at the ROB depth.
  always_comb begin
    for (int i = 0; i < NUM_READ; i++) begin
      r_addr[i] = head_ptr + ADDR_WIDTH'(i);
    end
  end

  retire_select #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .NUM_READ  (NUM_READ),
    .AREG_W    (AREG_W),
    .PC_W      (PC_W)
  ) u_select (
    .enable        (state == RUN),
    .occupied      (occupied),
    .ent_done      (ent_done),
    .ent_mispred   (ent_mispred),
    .ent_wen       (ent_wen),
    .ent_rd        (ent_rd),
    .ent_target    (ent_target),
    .pop           (rd),
    .commit_en     (commit_en),
    .mispred_hit   (mispred_hit),
    .mispred_target(mispred_target)
  );

  always_comb begin
    pop_count = '0;
    for (int i = 0; i < NUM_READ; i++) begin
      pop_count = pop_count + 32'(rd[i]);
    end
  end

  // FSM plus all registered outputs. Since retirement is gated to RUN,
  // a mispredict can only be seen in RUN, and flush is high exactly while
  // the FSM sits in FLUSH.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      flush        <= 1'b0;
      redirect_pc  <= '0;
      commit_valid <= '0;
      commit_rd    <= '0;
      commit_data  <= '0;
      instret      <= '0;
    end else begin
      commit_valid <= commit_en;
      commit_rd    <= ent_rd;
      commit_data  <= ent_data;
      instret      <= instret + pop_count;
      case (state)
        RUN: begin
          flush <= 1'b0;
          if (mispred_hit) begin
            state       <= FLUSH;
            flush       <= 1'b1;
            redirect_pc <= mispred_target;
          end
        end
        FLUSH: begin
          flush <= 1'b0;
          state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          flush <= 1'b0;
          if (flush_ack) begin
            state <= RUN;
          end
        end
        default: begin
          flush <= 1'b0;
          state <= RUN;
        end
      endcase
    end
  end

endmodule
